// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions: data width, default FIFO depth and entry width.
// Imported by the receive FIFO and intended for the receiver and TX FIFO too.
package uart_rx_fifo_pkg;

  // Width of a received UART word (up to 9 data bits).
  localparam int UART_DATA_W = 9;

  // Default FIFO depth, expressed as log2 of the number of entries.
  localparam int UART_FIFO_DEPTH_LOG2 = 4;

  // Each stored entry is {parity_err, data}.
  function automatic int uart_entry_w(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array FIFO storage: synchronous write, asynchronous read.
// Contents are deliberately not reset so the array maps onto plain flops or
// distributed RAM; shared between the RX and TX FIFOs.
module uart_fifo_mem #(
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 10
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [2**ADDR_W];

  // Store the incoming entry when the controller grants a write.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO between uart_rx and the bus read logic.
// Show-ahead read, sticky overflow, optional level interrupt enabled by
// defining UART_RX_FIFO_IRQ_EN (otherwise o_irq is tied low).
// Handshake: i_wr and i_rd are single-cycle strobes with no back-pressure;
// a write is taken when there is room (or a pop frees a slot the same cycle),
// a pop is taken when the FIFO is not empty; anything else is dropped.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2,
  parameter int DATA_W     = UART_DATA_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr,
  input  logic [DATA_W-1:0]     i_wr_data,
  input  logic                  i_wr_parity_err,
  input  logic                  i_rd,
  input  logic                  i_flush,
  input  logic [DEPTH_LOG2:0]   i_threshold,
  output logic [DATA_W-1:0]     o_rd_data,
  output logic                  o_rd_parity_err,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_irq
);

  localparam int ENTRY_W = uart_entry_w(DATA_W);
  localparam logic [DEPTH_LOG2:0] LP_DEPTH = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);

  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic                  w_drop;
  logic [DEPTH_LOG2:0]   w_count_nxt;
  logic                  w_overflow_nxt;
  logic [ENTRY_W-1:0]    w_rd_entry;

  // Count is the single source of truth for empty/full.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == LP_DEPTH);

  // A pop in the same cycle frees a slot, so a full FIFO still takes the write.
  assign w_wr_ok = i_wr && (!w_full || i_rd);
  assign w_rd_ok = i_rd && !w_empty;
  assign w_drop  = i_wr && w_full && !i_rd;

  // Next-state count and overflow; flush wins over same-cycle strobes.
  always_comb begin
    w_count_nxt    = r_count;
    w_overflow_nxt = r_overflow;
    if (i_flush) begin
      w_count_nxt    = '0;
      w_overflow_nxt = 1'b0;
    end else begin
      w_count_nxt    = r_count + {{DEPTH_LOG2{1'b0}}, w_wr_ok}
                               - {{DEPTH_LOG2{1'b0}}, w_rd_ok};
      w_overflow_nxt = r_overflow || w_drop;
    end
  end

  // Pointer, count and overflow registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_overflow <= w_overflow_nxt;
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  uart_fifo_mem #(
    .ADDR_W (DEPTH_LOG2),
    .WIDTH  (ENTRY_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_wr_ok && i_rst && !i_flush),
    .i_waddr (r_wr_ptr),
    .i_wdata ({i_wr_parity_err, i_wr_data}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_entry)
  );

  assign o_rd_data       = w_rd_entry[DATA_W-1:0];
  assign o_rd_parity_err = w_rd_entry[DATA_W];
  assign o_empty         = w_empty;
  assign o_full          = w_full;
  assign o_count         = r_count;
  assign o_overflow      = r_overflow;

`ifdef UART_RX_FIFO_IRQ_EN
  logic r_irq;

  // Level interrupt from next-state count so it tracks o_count exactly.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= ((w_count_nxt >= i_threshold) && (i_threshold != '0))
               || w_overflow_nxt;
    end
  end

  assign o_irq = r_irq;
`else
  logic w_unused_threshold;
  assign w_unused_threshold = ^i_threshold;
  assign o_irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (DEPTH_LOG2=4, DATA_W=9).
// Reference model: a queue of {parity_err, data} entries plus an overflow bit.
module tb_uart_rx_fifo;

  logic       i_clk;
  logic       i_rst;
  logic       i_wr;
  logic [8:0] i_wr_data;
  logic       i_wr_parity_err;
  logic       i_rd;
  logic       i_flush;
  logic [4:0] i_threshold;
  logic [8:0] o_rd_data;
  logic       o_rd_parity_err;
  logic       o_empty;
  logic       o_full;
  logic [4:0] o_count;
  logic       o_overflow;
  logic       o_irq;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [9:0] exp_q[$];
  logic       m_ovf;

  uart_rx_fifo #(.DEPTH_LOG2(4), .DATA_W(9)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_wr            (i_wr),
    .i_wr_data       (i_wr_data),
    .i_wr_parity_err (i_wr_parity_err),
    .i_rd            (i_rd),
    .i_flush         (i_flush),
    .i_threshold     (i_threshold),
    .o_rd_data       (o_rd_data),
    .o_rd_parity_err (o_rd_parity_err),
    .o_empty         (o_empty),
    .o_full          (o_full),
    .o_count         (o_count),
    .o_overflow      (o_overflow),
    .o_irq           (o_irq)
  );

  // Clock / reset block
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic model_irq();
`ifdef UART_RX_FIFO_IRQ_EN
    return ((exp_q.size() >= int'(i_threshold)) && (i_threshold != 0)) || m_ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Driver: called at a falling edge; applies strobes for one rising edge,
  // advances the model, and returns at the next falling edge.
  task automatic step(input logic wr, input logic [8:0] d, input logic pe,
                      input logic rd, input logic fl);
    bit was_full, was_empty, do_wr, do_rd;
    i_wr = wr; i_wr_data = d; i_wr_parity_err = pe; i_rd = rd; i_flush = fl;
    was_full  = (exp_q.size() == 16);
    was_empty = (exp_q.size() == 0);
    if (!i_rst || fl) begin
      exp_q.delete();
      m_ovf = 1'b0;
    end else begin
      do_rd = rd && !was_empty;
      do_wr = wr && (!was_full || rd);
      if (do_rd) void'(exp_q.pop_front());
      if (do_wr) exp_q.push_back({pe, d});
      if (wr && !do_wr) m_ovf = 1'b1;
    end
    @(posedge i_clk);
    @(negedge i_clk);
    i_wr = 1'b0; i_rd = 1'b0; i_flush = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    step(1'b1, 9'h055, 1'b0, 1'b0, 1'b0);
    step(1'b1, 9'h066, 1'b1, 1'b1, 1'b0);
    i_rst = 1'b1;
    checks++;
    if (o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", o_empty); end
    checks++;
    if (o_count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", o_count); end
    checks++;
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", o_overflow); end
    checks++;
    if (o_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", o_irq); end
    checks++;
    if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", o_full); end
  endtask

  task automatic test_basic();
    step(1'b1, 9'h041, 1'b0, 1'b0, 1'b0);
    step(1'b1, 9'h1FF, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({o_rd_parity_err, o_rd_data} !== 10'h041)
      begin errors++; $display("FAIL basic_head0 got=%h exp=041", {o_rd_parity_err, o_rd_data}); end
    checks++;
    if (o_count !== 5'd2) begin errors++; $display("FAIL basic_count2 got=%0d exp=2", o_count); end
    step(1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({o_rd_parity_err, o_rd_data} !== 10'h3FF)
      begin errors++; $display("FAIL basic_head1 got=%h exp=3ff", {o_rd_parity_err, o_rd_data}); end
    step(1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
    checks++;
    if (o_empty !== 1'b1 || o_count !== 5'd0)
      begin errors++; $display("FAIL basic_drained empty=%b count=%0d exp empty=1 count=0", o_empty, o_count); end
    // Pop while empty is ignored and raises nothing
    step(1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
    checks++;
    if (o_count !== 5'd0 || o_overflow !== 1'b0)
      begin errors++; $display("FAIL basic_empty_pop count=%0d ovf=%b exp 0/0", o_count, o_overflow); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) step(1'b1, 9'(i), 1'b0, 1'b0, 1'b0);
    checks++;
    if (o_full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%b exp=1", o_full); end
    step(1'b1, 9'h0AA, 1'b0, 1'b0, 1'b0);
    checks++;
    if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", o_overflow); end
    checks++;
    if (o_count !== 5'd16) begin errors++; $display("FAIL ovf_count got=%0d exp=16", o_count); end
    checks++;
    if (o_irq !== model_irq()) begin errors++; $display("FAIL ovf_irq got=%b exp=%b", o_irq, model_irq()); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (o_rd_data !== 9'(i)) begin errors++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, o_rd_data, 9'(i)); end
      step(1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
    end
    checks++;
    if (o_empty !== 1'b1 || o_overflow !== 1'b1)
      begin errors++; $display("FAIL ovf_after empty=%b ovf=%b exp 1/1", o_empty, o_overflow); end
  endtask

  task automatic test_flush();
    step(1'b1, 9'h011, 1'b0, 1'b0, 1'b0);
    step(1'b1, 9'h022, 1'b0, 1'b0, 1'b1);   // flush beats the write
    checks++;
    if (o_count !== 5'd0 || o_empty !== 1'b1 || o_overflow !== 1'b0)
      begin errors++; $display("FAIL flush count=%0d empty=%b ovf=%b exp 0/1/0", o_count, o_empty, o_overflow); end
  endtask

  task automatic test_full_wr_rd();
    logic [8:0] last;
    for (int i = 0; i < 16; i++) step(1'b1, 9'(i + 16), 1'b0, 1'b0, 1'b0);
    step(1'b1, 9'h123, 1'b0, 1'b1, 1'b0);
    checks++;
    if (o_count !== 5'd16 || o_overflow !== 1'b0)
      begin errors++; $display("FAIL full_wrrd count=%0d ovf=%b exp 16/0", o_count, o_overflow); end
    last = 9'h000;
    for (int i = 0; i < 16; i++) begin
      last = o_rd_data;
      step(1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
    end
    checks++;
    if (last !== 9'h123) begin errors++; $display("FAIL full_wrrd_last got=%h exp=123", last); end
    // Write and pop together while empty: write taken, count becomes 1
    step(1'b1, 9'h0C3, 1'b1, 1'b1, 1'b0);
    checks++;
    if (o_count !== 5'd1 || {o_rd_parity_err, o_rd_data} !== 10'h2C3)
      begin errors++; $display("FAIL empty_wrrd count=%0d head=%h exp 1/2c3", o_count, {o_rd_parity_err, o_rd_data}); end
    step(1'b0, 9'h000, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_irq();
    i_threshold = 5'd3;
    step(1'b1, 9'h001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 9'h002, 1'b0, 1'b0, 1'b0);
    checks++;
    if (o_irq !== 1'b0) begin errors++; $display("FAIL irq_two got=%b exp=0", o_irq); end
    step(1'b1, 9'h003, 1'b0, 1'b0, 1'b0);
    checks++;
    if (o_irq !== model_irq()) begin errors++; $display("FAIL irq_three got=%b exp=%b", o_irq, model_irq()); end
    step(1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
    checks++;
    if (o_irq !== 1'b0) begin errors++; $display("FAIL irq_fall got=%b exp=0", o_irq); end
    step(1'b0, 9'h000, 1'b0, 1'b0, 1'b1);
    checks++;
    if (o_count !== 5'd0 || o_overflow !== 1'b0 || o_irq !== 1'b0)
      begin errors++; $display("FAIL irq_flush count=%0d ovf=%b irq=%b exp 0/0/0", o_count, o_overflow, o_irq); end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 5; i++) step(1'b1, 9'(i + 9'h100), 1'b0, 1'b0, 1'b0);
    i_rst = 1'b0;
    step(1'b1, 9'h1AA, 1'b0, 1'b1, 1'b0);
    i_rst = 1'b1;
    checks++;
    if (o_count !== 5'd0 || o_empty !== 1'b1)
      begin errors++; $display("FAIL midreset count=%0d empty=%b exp 0/1", o_count, o_empty); end
  endtask

  task automatic test_random();
    logic       wr, rd, pe;
    logic [8:0] d;
    for (int i = 0; i < 13; i++) step(1'b1, 9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    for (int c = 0; c < 60; c++) begin
      i_threshold = 5'($urandom_range(0, 16));
      wr = ($urandom_range(0, 99) < 60);
      rd = ($urandom_range(0, 99) < 55);
      pe = 1'($urandom_range(0, 1));
      d  = 9'($urandom_range(0, 511));
      step(wr, d, pe, rd, 1'b0);
      checks++;
      if (o_count !== 5'(exp_q.size()))
        begin errors++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, o_count, exp_q.size()); end
      checks++;
      if (o_empty !== (exp_q.size() == 0) || o_full !== (exp_q.size() == 16))
        begin errors++; $display("FAIL rand_flags c=%0d empty=%b full=%b size=%0d", c, o_empty, o_full, exp_q.size()); end
      checks++;
      if (o_overflow !== m_ovf || o_irq !== model_irq())
        begin errors++; $display("FAIL rand_ovf_irq c=%0d ovf=%b/%b irq=%b/%b", c, o_overflow, m_ovf, o_irq, model_irq()); end
      if (exp_q.size() != 0) begin
        checks++;
        if ({o_rd_parity_err, o_rd_data} !== exp_q[0])
          begin errors++; $display("FAIL rand_head c=%0d got=%h exp=%h", c, {o_rd_parity_err, o_rd_data}, exp_q[0]); end
      end
    end
  endtask

  initial begin
    i_rst = 1'b0; i_wr = 1'b0; i_wr_data = '0; i_wr_parity_err = 1'b0;
    i_rd = 1'b0; i_flush = 1'b0; i_threshold = 5'd0; m_ovf = 1'b0;
    @(negedge i_clk);
    test_reset();
    test_basic();
    test_overflow();
    test_flush();
    test_full_wr_rd();
    test_irq();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
